lock_entry_conditioner: RTL and testbench
=========================================

// Module: lock_entry_conditioner
// PURPOSE
//  Input stage directly upstream of the combination-lock FSM on the DE1-SoC.
//  Synchronises and debounces the raw active-low ENTER pushbutton and the
//  SW[3:0] digit switches. Emits one clean digit per debounced press.
//  Counts entered digits so the lock FSM sees a one-cycle "digit entered"
//  strobe plus a captured digit, instead of a bouncing KEY used as a clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  stable cycles required per edge (10 ms @ 50 MHz); must be >= 2
//  CNT_W            19      debounce counter width; must hold DEBOUNCE_CYCLES-1
//  NUM_DIGITS       6       digits per combination; entry_count saturation value
// PORTS
//  clk            in   1      system clock (CLOCK_50)
//  reset          in   1      asynchronous, active-high reset
//  key_n_in       in   1      raw ENTER pushbutton, active-low, asynchronous
//  sw_in          in   4      raw digit switches SW[3:0], asynchronous
//  clear          in   1      synchronous pulse from lock FSM: restart digit count
//  digit_valid    out  1      one-cycle strobe: new debounced digit captured
//  digit_out      out  4      captured digit; holds until the next digit_valid
//  digit_invalid  out  1      captured digit > 9; updates with digit_valid
//  entry_count    out  3      digits accepted since reset/clear, saturates at NUM_DIGITS
//  seq_done       out  1      high while entry_count == NUM_DIGITS
//  key_level      out  1      debounced pressed level: 1 in HELD/REL_CHK
// BEHAVIOUR
//  Reset: while reset=1, all outputs and sync FFs are 0 and the FSM is IDLE.
//  - Reset is asynchronous and may be asserted in any state.
//  Sync: 2-FF synchroniser on ~key_n_in (key_sync) and on sw_in (sw_sync).
//  - Both synchronisers reset to 0.
//  FSM states: IDLE, PRESS_CHK, HELD, REL_CHK. One counter cnt, cleared on each state entry.
//  - IDLE:      key_sync=1 -> PRESS_CHK.
//  - PRESS_CHK: key_sync=0 -> IDLE.
//               Otherwise cnt++. On the cycle cnt==DEBOUNCE_CYCLES-1:
//               -> HELD; register digit_valid=1, digit_out=sw_sync, digit_invalid=(sw_sync>9).
//  - HELD:      key_sync=0 -> REL_CHK.
//  - REL_CHK:   key_sync=1 -> HELD. No new digit is emitted.
//               Otherwise cnt++. At cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//  Latency: with the press stable, digit_valid is high during the cycle after
//  rising edge DEBOUNCE_CYCLES+3. Edge 1 is the first edge that samples key_n_in=0.
//  digit_valid: exactly one pulse per debounced press. Never emitted on release.
//  Holding the button never re-triggers.
//  Bounce shorter than DEBOUNCE_CYCLES in either direction produces no pulse and no state change.
//  - A short release glitch in HELD returns to HELD; a short press glitch in IDLE returns to IDLE.
//  entry_count: +1 on each digit_valid, saturates at NUM_DIGITS.
//  - digit_valid still pulses after saturation; digit_out still updates.
//  clear: entry_count -> 0 next cycle.
//  - clear and digit_valid in the same cycle -> entry_count=1 (the new digit is the first).
//  - clear does not affect the FSM, digit_out or digit_invalid.
//  Button held through reset release: treated as a fresh press, full debounce, one pulse.
//  Reset mid-PRESS_CHK aborts the press; no pulse is emitted for it.
// TESTING  (DEBOUNCE_CYCLES=4, NUM_DIGITS=6)
//  1 reset=1 with random inputs -> all outputs 0; release reset, buttons idle -> outputs stay 0.
//  2 sw_in=3, key_n_in low 12 cycles then high 12 -> one digit_valid after edge 7;
//    digit_out=3, entry_count=1, key_level 1 then 0; no pulse on release.
//  3 bounce: low 2/high 1/low 3/high 2 cycles, then stable low -> no pulse during bounce;
//    exactly one pulse after stable debounce.
//  4 six clean presses with digits 1..6 -> entry_count 1..6, seq_done=1 after 6th;
//    7th press (digit 9) -> digit_valid=1, digit_out=9, entry_count stays 6.
//  5 sw_in=4'hA press -> digit_valid=1, digit_out=A, digit_invalid=1;
//    next press with sw_in=2 -> digit_invalid=0.
//  6 clear coincident with digit_valid -> entry_count=1.
//    reset asserted 2 cycles into PRESS_CHK -> no digit_valid, outputs 0, FSM IDLE.

Source files
------------

// File: rtl/lock_entry_conditioner.sv
// Conditions the raw ENTER key and digit switches into one clean digit strobe per debounced press.
// A press is accepted after DEBOUNCE_CYCLES stable cycles; the entry count follows the strobe by one cycle.
module lock_entry_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int NUM_DIGITS      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n_in,
    input  logic [3:0] sw_in,
    input  logic       clear,
    output logic       digit_valid,
    output logic [3:0] digit_out,
    output logic       digit_invalid,
    output logic [2:0] entry_count,
    output logic       seq_done,
    output logic       key_level
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       COUNT_MAX = 3'(NUM_DIGITS);

    logic             key_meta, key_sync;
    logic [3:0]       sw_meta, sw_sync;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture;

    // The key is inverted before synchronising so key_sync is 1 while pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            sw_meta  <= 4'd0;
            sw_sync  <= 4'd0;
        end else begin
            key_meta <= ~key_n_in;
            key_sync <= key_meta;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (key_sync) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                end
            end
            REL_CHK: begin
                if (key_sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_valid   <= 1'b0;
            digit_out     <= 4'd0;
            digit_invalid <= 1'b0;
        end else begin
            digit_valid <= capture;
            if (capture) begin
                digit_out     <= sw_sync;
                digit_invalid <= (sw_sync > 4'd9);
            end
        end
    end

    // A clear that coincides with a strobe keeps that digit as the first of the new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_count <= 3'd0;
        end else if (clear) begin
            entry_count <= digit_valid ? 3'd1 : 3'd0;
        end else if (digit_valid && (entry_count != COUNT_MAX)) begin
            entry_count <= entry_count + 3'd1;
        end
    end

    assign seq_done  = (entry_count == COUNT_MAX);
    assign key_level = (state == HELD) || (state == REL_CHK);

endmodule

// File: tb/tb_lock_entry_conditioner.sv
// Directed bench for lock_entry_conditioner with a 4-cycle debounce and 6-digit entries.
module tb_lock_entry_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n_in;
    logic [3:0] sw_in;
    logic       clear;
    logic       digit_valid;
    logic [3:0] digit_out;
    logic       digit_invalid;
    logic [2:0] entry_count;
    logic       seq_done;
    logic       key_level;

    int         total = 0;
    int         bad   = 0;
    int         pulses;
    int         first_edge;
    int         cyc;
    logic [3:0] last_dout;
    logic       last_inv;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] dout;
        logic       inv;
        logic [2:0] cnt;
        logic       seq;
    } vec_t;

    vec_t tbl[9];

    lock_entry_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .NUM_DIGITS(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n_in(key_n_in),
        .sw_in(sw_in),
        .clear(clear),
        .digit_valid(digit_valid),
        .digit_out(digit_out),
        .digit_invalid(digit_invalid),
        .entry_count(entry_count),
        .seq_done(seq_done),
        .key_level(key_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Holds the key at level k for n clock edges, recording strobes seen at each falling edge.
    task automatic drive(input logic k, input int n);
        key_n_in = k;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (digit_valid) begin
                pulses++;
                if (pulses == 1) first_edge = cyc;
                last_dout = digit_out;
                last_inv  = digit_invalid;
            end
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {digit_valid, digit_out, digit_invalid, entry_count, seq_done, key_level};
    endfunction

    initial begin
        bit found;

        tbl[0] = '{4'd1, 4'd1, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{4'd2, 4'd2, 1'b0, 3'd2, 1'b0};
        tbl[2] = '{4'd3, 4'd3, 1'b0, 3'd3, 1'b0};
        tbl[3] = '{4'd4, 4'd4, 1'b0, 3'd4, 1'b0};
        tbl[4] = '{4'd5, 4'd5, 1'b0, 3'd5, 1'b0};
        tbl[5] = '{4'd6, 4'd6, 1'b0, 3'd6, 1'b1};
        tbl[6] = '{4'd9, 4'd9, 1'b0, 3'd6, 1'b1};
        tbl[7] = '{4'hA, 4'hA, 1'b1, 3'd6, 1'b1};
        tbl[8] = '{4'd2, 4'd2, 1'b0, 3'd6, 1'b1};

        reset = 1'b1; key_n_in = 1'b1; sw_in = 4'd0; clear = 1'b0;
        pulses = 0; first_edge = 0; cyc = 0; last_dout = 4'd0; last_inv = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            key_n_in = 1'($urandom);
            sw_in    = 4'($urandom);
            clear    = 1'($urandom);
            @(negedge clk);
            check("reset_outs", 32'(all_outs()), 32'd0);
        end
        key_n_in = 1'b1; sw_in = 4'd0; clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        drive(1'b1, 10);
        check("idle_pulses", pulses, 0);
        check("idle_outs", 32'(all_outs()), 32'd0);

        // Single clean press
        sw_in = 4'd3; pulses = 0; cyc = 0;
        drive(1'b0, 12);
        check("press_pulses", pulses, 1);
        check("press_edge", first_edge, 7);
        check("press_dout", last_dout, 3);
        check("press_inv", last_inv, 0);
        check("press_count", entry_count, 1);
        check("press_level", key_level, 1);
        drive(1'b1, 12);
        check("release_pulses", pulses, 1);
        check("release_level", key_level, 0);
        check("release_dout_hold", digit_out, 3);

        // Bounce then a stable press
        sw_in = 4'd7; pulses = 0;
        drive(1'b0, 2); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 2);
        check("bounce_pulses", pulses, 0);
        check("bounce_level", key_level, 0);
        drive(1'b0, 12);
        drive(1'b1, 12);
        check("bounce_stable_pulses", pulses, 1);
        check("bounce_dout", last_dout, 7);
        check("bounce_count", entry_count, 2);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_count", entry_count, 0);
        check("clear_dout_hold", digit_out, 7);

        // Six digits, saturation, invalid digit
        for (int i = 0; i < 9; i++) begin
            sw_in = tbl[i].sw; pulses = 0;
            drive(1'b0, 10);
            drive(1'b1, 10);
            check($sformatf("vec%0d_pulses", i), pulses, 1);
            check($sformatf("vec%0d_dout", i), last_dout, tbl[i].dout);
            check($sformatf("vec%0d_inv", i), last_inv, tbl[i].inv);
            check($sformatf("vec%0d_count", i), entry_count, tbl[i].cnt);
            check($sformatf("vec%0d_seq", i), seq_done, tbl[i].seq);
        end

        // Clear coincident with the strobe
        sw_in = 4'd5; key_n_in = 1'b0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (digit_valid) found = 1'b1;
        end
        check("clr_strobe_seen", 32'(found), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_coincident_count", entry_count, 1);
        check("clr_coincident_dout", digit_out, 5);
        check("clr_coincident_seq", seq_done, 0);
        pulses = 0;
        drive(1'b1, 10);
        check("clr_release_pulses", pulses, 0);
        check("clr_count_hold", entry_count, 1);

        // Reset two cycles into PRESS_CHK
        sw_in = 4'd8; key_n_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outs", 32'(all_outs()), 32'd0);
        key_n_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        drive(1'b1, 12);
        check("abort_pulses", pulses, 0);
        check("abort_outs_after", 32'(all_outs()), 32'd0);

        // Key held through reset release counts as a fresh press
        reset = 1'b1; key_n_in = 1'b0; sw_in = 4'd8;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0; cyc = 0;
        drive(1'b0, 12);
        check("held_rst_pulses", pulses, 1);
        check("held_rst_edge", first_edge, 7);
        check("held_rst_dout", last_dout, 8);
        drive(1'b1, 12);
        check("held_rst_total_pulses", pulses, 1);
        check("held_rst_count", entry_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
